uart_cmd_parser: RTL
====================

# uart_cmd_parser

Byte-level command frame decoder downstream of the UART receiver. It consumes the receiver's `RxData`/`RxDone` byte stream and hunts for a sync byte. It then assembles a frame (command, length, payload, checksum), streams the payload into an external buffer, and reports each frame as either a validated command or an error. It sits between the UART RX stage and the instrument's register/command logic.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_LEN`, default 15: largest accepted payload length. Must be ≤ 15, because `PayAddr` and `CmdLen` are 4 bits.
- `TIMEOUT_TICKS`, default 4096: inter-byte gap limit, counted in `Tick` rising edges. Only used with the timeout macro.
- `Clk`  in  1  system clock; all logic is rising-edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `En`  in  1  parser enable; low forces IDLE.
- `RxData`  in  8  received byte; stable while `RxDone` is high.
- `RxDone`  in  1  byte-complete strobe from the UART RX, one or more `Clk` cycles wide.
- `Tick`  in  1  16× oversampling baud tick, shared with the UART RX.
- `Busy`  out  1  high in any state other than IDLE.
- `PayWe`  out  1  one-cycle payload write strobe.
- `PayAddr`  out  4  payload byte index, 0-based.
- `PayData`  out  8  payload byte.
- `CmdValid`  out  1  one-cycle pulse when a good frame completes.
- `CmdCode`  out  8  command byte; held until the next frame's CMD byte.
- `CmdLen`  out  4  payload length; held with `CmdCode`.
- `CmdErr`  out  1  one-cycle pulse on a frame error.
- `ErrCode`  out  2  error cause: 01 checksum, 10 length, 11 timeout. Held until the next `CmdErr`.

## Operation
- **Byte event:** the first `Clk` cycle in which `RxDone` is seen high after being low. `RxDone` is edge-detected by a register. `RxData` is captured in that cycle, so a wide `RxDone` produces exactly one event.
- **IDLE:**
  - A byte equal to `SYNC_BYTE` moves to CMD. Any other byte is discarded silently.
  - Entering CMD clears the checksum accumulator `Sum` to 0.
- **CMD:** the byte goes to `CmdCode`; `Sum` += byte; move to LEN.
- **LEN:**
  - `Sum` += byte.
  - If the byte is greater than `MAX_LEN`: pulse `CmdErr` with `ErrCode`=10, then go to IDLE.
  - Otherwise load `CmdLen` (low 4 bits) and zero the payload index.
  - Go to PAYLOAD if the length is nonzero, else to CSUM.
- **PAYLOAD:**
  - Per byte: `PayWe`=1, `PayAddr`=index, `PayData`=byte; `Sum` += byte; index += 1.
  - After the byte at index `CmdLen`-1, go to CSUM.
- **CSUM:**
  - If (`Sum` + byte) mod 256 == 0: pulse `CmdValid`.
  - Otherwise: pulse `CmdErr` with `ErrCode`=01.
  - Go to IDLE in either case.
- **Arithmetic:** `Sum` is 8 bits and wraps modulo 256. The checksum byte is the two's complement of (CMD+LEN+payload).
- **Payload buffer:** contents are meaningful only at `CmdValid`. A failed frame may leave a partially overwritten buffer.
- **`En` low:** returns to IDLE in the next cycle with no `CmdErr`. Byte events are ignored while `En` is low.
- **Reset (async):**
  - State goes to IDLE.
  - `Sum`, index and the timer go to 0.
  - All outputs go to 0: `Busy`, `PayWe`, `PayAddr`, `PayData`, `CmdValid`, `CmdCode`, `CmdLen`, `CmdErr`, `ErrCode`.
  - Assertion mid-frame discards the frame with no pulse.

## Timing
- `PayWe`, `CmdValid` and `CmdErr` rise exactly one `Clk` after the byte-event cycle and last one cycle.
- `CmdValid` and `CmdErr` are never high together.
- Back-to-back frames are supported. A new `SYNC_BYTE` event may arrive in the cycle that `CmdValid` is high; it is accepted because the state is already IDLE.
- The parser never stalls and has no backpressure. The downstream consumer must accept a `PayWe` every byte time.

## Configuration
- **Macro:** `UART_CMD_TIMEOUT_EN`.
- **With the macro:**
  - A gap counter increments on each `Tick` rising edge while `Busy` is high. It clears on every byte event and on entry to IDLE.
  - When the count reaches `TIMEOUT_TICKS`: pulse `CmdErr` with `ErrCode`=11, then go to IDLE.
  - If a byte event and a timeout occur in the same cycle, the byte wins and the timer clears.
- **Without the macro:**
  - No timer logic is built and `ErrCode` never takes the value 11.
  - A truncated frame waits indefinitely until `En` goes low, reset is asserted, or more bytes arrive.

## Structure
- **Shared package `uart_cmd_pkg`:**
  - State enum: IDLE, CMD, LEN, PAYLOAD, CSUM.
  - `ErrCode` constants: `ERR_CSUM`=2'b01, `ERR_LEN`=2'b10, `ERR_TIMEOUT`=2'b11.
  - Default `SYNC_BYTE`.
- **Sub-module `uart_gap_timer`:**
  - Contains the `Tick` edge detector and the gap counter with its terminal-count compare.
  - Instantiated only under `UART_CMD_TIMEOUT_EN`.

## Test plan
- **Valid frame:** bytes A5 10 02 11 22 BB.
  - `PayWe` at addr0=11 and addr1=22.
  - `CmdValid` pulse with `CmdCode`=10, `CmdLen`=2.
  - No `CmdErr`.
- **Zero-length frame with leading garbage:** bytes 00 FF A5 05 00 FB.
  - Garbage bytes are ignored.
  - No `PayWe`.
  - `CmdValid` pulse with `CmdCode`=05, `CmdLen`=0.
- **Bad checksum:** bytes A5 10 02 11 22 BC.
  - `CmdErr` pulse with `ErrCode`=01.
  - The following valid frame is decoded correctly.
- **Length over limit:** bytes A5 10 20.
  - `CmdErr` pulse with `ErrCode`=10 one cycle after the LEN byte.
  - The next payload-like bytes are treated as sync hunting.
- **Timeout (macro on, `TIMEOUT_TICKS`=64):** bytes A5 10, then 64 ticks of silence.
  - `CmdErr` pulse with `ErrCode`=11; `Busy` falls.
  - With the macro off, `Busy` stays high.
- **Reset mid-payload:**
  - Assert `Rst_n` low after the third byte: all outputs go to 0 immediately, with no pulse.
  - After release, a valid frame decodes normally.
  - Repeat with `RxDone` held high for 20 cycles: exactly one byte event is generated.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command frame parser:
//   - state_e      : parser FSM states
//   - ERR_*        : ErrCode values reported with CmdErr
//   - DEFAULT_SYNC_BYTE : default frame start marker
//   - csum_add()   : modulo-256 checksum accumulate
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_e;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Checksum accumulator wraps modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// -----------------------------------------------------------------------------
// uart_gap_timer
// Inter-byte gap timer used when UART_CMD_TIMEOUT_EN is defined.
// Counts rising edges of the baud Tick while Run is high and flags Timeout
// once TIMEOUT_TICKS edges have been seen since the last Clr.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   Tick       : 16x oversampling tick (edge detected here)
//   Run        : count enable (parser busy)
//   Clr        : synchronous clear (byte event or return to IDLE)
//   Timeout    : terminal count reached
// -----------------------------------------------------------------------------
module uart_gap_timer #(
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Tick,
  input  logic Run,
  input  logic Clr,
  output logic Timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

  logic             tick_q;
  logic             tick_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_rise = Tick & ~tick_q;
  assign Timeout   = (cnt_q == CNT_W'(TIMEOUT_TICKS));

  // Counter holds at terminal count until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (Run && tick_rise && !Timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tick_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      tick_q <= Tick;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Byte-level frame decoder behind the UART receiver. Hunts for SYNC_BYTE,
// then assembles CMD, LEN, payload and checksum; payload bytes are streamed
// out on PayWe/PayAddr/PayData, and each frame ends with a CmdValid or CmdErr
// pulse.
// Optional feature: define UART_CMD_TIMEOUT_EN to build the inter-byte gap
// timer (uart_gap_timer) that aborts a stalled frame with ErrCode 11.
// Ports:
//   Clk, Rst_n         : clock, asynchronous active-low reset
//   En                 : parser enable (low forces IDLE, ignores bytes)
//   RxData, RxDone     : byte and completion strobe from the UART RX
//   Tick               : baud tick (used only by the gap timer)
//   Busy               : not in IDLE
//   PayWe/PayAddr/PayData : payload buffer write port
//   CmdValid, CmdCode, CmdLen : good-frame pulse and its command/length
//   CmdErr, ErrCode    : frame-error pulse and cause
// -----------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN       = 15,
  parameter int         TIMEOUT_TICKS = 4096
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic [7:0] RxData,
  input  logic       RxDone,
  input  logic       Tick,
  output logic       Busy,
  output logic       PayWe,
  output logic [3:0] PayAddr,
  output logic [7:0] PayData,
  output logic       CmdValid,
  output logic [7:0] CmdCode,
  output logic [3:0] CmdLen,
  output logic       CmdErr,
  output logic [1:0] ErrCode
);

  state_e     state_q, state_d;
  logic       rxdone_q;
  logic [7:0] sum_q, sum_d;
  logic [3:0] idx_q, idx_d;

  logic       busy_q, busy_d;
  logic       pay_we_q, pay_we_d;
  logic [3:0] pay_addr_q, pay_addr_d;
  logic [7:0] pay_data_q, pay_data_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_code_q, cmd_code_d;
  logic [3:0] cmd_len_q, cmd_len_d;
  logic       cmd_err_q, cmd_err_d;
  logic [1:0] err_code_q, err_code_d;

  logic       byte_evt;
  logic       timeout;
  logic [7:0] sum_add;

  // One event per RxDone pulse regardless of its width.
  assign byte_evt = En & RxDone & ~rxdone_q;
  assign sum_add  = csum_add(sum_q, RxData);

`ifdef UART_CMD_TIMEOUT_EN
  uart_gap_timer #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_gap_timer (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Tick    (Tick),
    .Run     (busy_q),
    .Clr     (byte_evt | (state_d == ST_IDLE)),
    .Timeout (timeout)
  );
`else
  logic        unused_tick;
  logic [31:0] unused_timeout_ticks;
  assign unused_tick          = Tick;
  assign unused_timeout_ticks = TIMEOUT_TICKS;
  assign timeout              = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    pay_we_d    = 1'b0;
    pay_addr_d  = pay_addr_q;
    pay_data_d  = pay_data_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    cmd_len_d   = cmd_len_q;
    cmd_err_d   = 1'b0;
    err_code_d  = err_code_q;

    if (!En) begin
      state_d = ST_IDLE;
    end else if (byte_evt) begin
      // A byte event outranks a coincident timeout.
      unique case (state_q)
        ST_IDLE: begin
          if (RxData == SYNC_BYTE) begin
            state_d = ST_CMD;
            sum_d   = 8'h00;
          end
        end
        ST_CMD: begin
          cmd_code_d = RxData;
          sum_d      = sum_add;
          state_d    = ST_LEN;
        end
        ST_LEN: begin
          sum_d = sum_add;
          if (RxData > 8'(MAX_LEN)) begin
            cmd_err_d  = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            cmd_len_d = RxData[3:0];
            idx_d     = 4'd0;
            state_d   = (RxData == 8'h00) ? ST_CSUM : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pay_we_d   = 1'b1;
          pay_addr_d = idx_q;
          pay_data_d = RxData;
          sum_d      = sum_add;
          idx_d      = idx_q + 4'd1;
          if (idx_q == cmd_len_q - 4'd1) begin
            state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (sum_add == 8'h00) begin
            cmd_valid_d = 1'b1;
          end else begin
            cmd_err_d  = 1'b1;
            err_code_d = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout && state_q != ST_IDLE) begin
      cmd_err_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      rxdone_q    <= 1'b0;
      sum_q       <= 8'h00;
      idx_q       <= 4'd0;
      busy_q      <= 1'b0;
      pay_we_q    <= 1'b0;
      pay_addr_q  <= 4'd0;
      pay_data_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      cmd_len_q   <= 4'd0;
      cmd_err_q   <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      rxdone_q    <= RxDone;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      pay_we_q    <= pay_we_d;
      pay_addr_q  <= pay_addr_d;
      pay_data_q  <= pay_data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_len_q   <= cmd_len_d;
      cmd_err_q   <= cmd_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign Busy     = busy_q;
  assign PayWe    = pay_we_q;
  assign PayAddr  = pay_addr_q;
  assign PayData  = pay_data_q;
  assign CmdValid = cmd_valid_q;
  assign CmdCode  = cmd_code_q;
  assign CmdLen   = cmd_len_q;
  assign CmdErr   = cmd_err_q;
  assign ErrCode  = err_code_q;

endmodule
